// File: rtl/serial_mag_cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: the one-hot
// {gt,eq,lt} result codes and the controller state type.
package cmp_pkg;

    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/serial_mag_cmp_slice.sv
// 4-bit magnitude compare slice with cascade input, functionally the same
// as a 74HC85: a strict difference in this nibble decides, otherwise the
// verdict of the less significant nibbles (cascade input) passes through.
module cmp4_slice
    import cmp_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] i,
    output logic [2:0] o
);

    // Local nibble decides on inequality, otherwise forward the cascade.
    always_comb begin
        o = i;
        if (a > b) begin
            o = CMP_GT;
        end else if (a < b) begin
            o = CMP_LT;
        end
    end

endmodule

// File: rtl/serial_mag_cmp.sv
// Serial wide magnitude comparator: walks the operands one nibble per clock,
// LSB nibble first, feeding each slice result back as the cascade input of
// the next more significant nibble. Start/busy/done handshake, registered
// outputs only.
module serial_mag_cmp
    import cmp_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             y
);

    localparam int W     = 4 * NIBBLES;
    // A single-nibble compare still needs a one-bit index register.
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    cmp_state_t       state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [2:0]       casc;
    logic [IDX_W-1:0] idx;

    logic [3:0]       a_nib [NIBBLES];
    logic [3:0]       b_nib [NIBBLES];
    logic [3:0]       a_sel;
    logic [3:0]       b_sel;
    logic [2:0]       slice_out;

    // Split the latched operands into nibbles for the index-driven mux.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_q[4*gi +: 4];
            assign b_nib[gi] = b_q[4*gi +: 4];
        end
    endgenerate

    assign a_sel = a_nib[idx];
    assign b_sel = b_nib[idx];

    cmp4_slice u_slice (
        .a (a_sel),
        .b (b_sel),
        .i (casc),
        .o (slice_out)
    );

    // Controller: operand capture, nibble sequencing and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            casc  <= CMP_EQ;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            y     <= CMP_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        casc  <= CMP_EQ;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    casc <= slice_out;
                    if (idx == LAST_IDX) begin
                        // Most significant nibble: the slice output is the
                        // final verdict, so publish it directly.
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        y     <= slice_out;
                        state <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Directed and random bench for serial_mag_cmp (NIBBLES=2). Expected results
// are pushed to a scoreboard queue at start and popped when done pulses.
module tb_serial_mag_cmp;

    localparam int NIBBLES = 2;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [2:0]   y;

    int           tests = 0;
    int           fails = 0;
    logic [2:0]   exp_q[$];

    serial_mag_cmp #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model(input logic [W-1:0] x, input logic [W-1:0] z);
        return {x > z, x == z, x < z};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after
    // the accepting edge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input bit push);
        a     = av;
        b     = bv;
        start = 1'b1;
        if (push) exp_q.push_back(model(av, bv));
        @(negedge clk);
        start = 1'b0;
        $display("[TB] start a=%02h b=%02h", av, bv);
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
    endtask

    // Waits (bounded) for done; 'already' is cycles elapsed since acceptance.
    task automatic wait_done(input int already, input string tag);
        int         cyc;
        bit         seen;
        logic [2:0] e;
        cyc  = already;
        seen = 1'b0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
            check({tag, "_latency"}, cyc, NIBBLES);
            check({tag, "_busy_in_done"}, busy, 0);
            check({tag, "_y"}, y, e);
            $display("[TB] %s done y=%03b expected=%03b latency=%0d", tag, y, e, cyc);
            @(negedge clk);
            check({tag, "_done_pulse"}, done, 0);
            check({tag, "_y_hold"}, y, e);
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_y", y, 3'b000);
        rst = 1'b0;
        @(negedge clk);

        issue(8'h35, 8'h35, 1'b1); wait_done(0, "equal");
        issue(8'h4A, 8'h4B, 1'b1); wait_done(0, "low_lt");
        issue(8'h4C, 8'h4B, 1'b1); wait_done(0, "low_gt");
        issue(8'h5A, 8'h4F, 1'b1); wait_done(0, "high_gt");
        issue(8'h3F, 8'h40, 1'b1); wait_done(0, "high_lt");

        // Start and operand changes during RUN must be ignored.
        issue(8'h10, 8'h20, 1'b1);
        a     = 8'hFF;
        b     = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignore_running", busy, 1);
        check("busy_ignore_no_done", done, 0);
        wait_done(1, "busy_ignore");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_no_done", done, 0);
            check("idle_no_busy", busy, 0);
            check("idle_y_hold", y, 3'b001);
        end

        // Reset one cycle into RUN aborts the compare.
        issue(8'h12, 8'h34, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_y", y, 3'b000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_y_clear", y, 3'b000);
        end
        issue(8'h00, 8'h00, 1'b1); wait_done(0, "after_abort");

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = (i % 5 == 0) ? ra : W'($urandom_range(0, 255));
            issue(ra, rb, 1'b1);
            wait_done(0, "random");
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
